// File: rtl/dpll_pkg.sv
// Shared DPLL definitions: detector state encoding, default error width and
// the saturating counter helper.
package dpll_pkg;

   localparam int DEFAULT_ERR_WIDTH = 12;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REF_LEAD = 2'd1,
      FB_LEAD  = 2'd2
   } pd_state_t;

   // Increment that sticks at maxVal instead of wrapping.
   function automatic int unsigned satInc(input int unsigned value, input int unsigned maxVal);
      return (value >= maxVal) ? maxVal : value + 1;
   endfunction

endpackage

// File: rtl/counting_phase_detector_if.sv
// Signal bundle between the phase detector and its environment: detector
// inputs on one side, error word and up/down/slip indications on the other.
interface counting_phase_detector_if #(
   parameter int ERR_WIDTH = dpll_pkg::DEFAULT_ERR_WIDTH
);

   logic                        enable;
   logic                        refSig;
   logic                        fbSig;
   logic signed [ERR_WIDTH-1:0] errSig;
   logic                        errValid;
   logic                        upSig;
   logic                        dnSig;
   logic                        slipSig;

   modport master (
      output enable, refSig, fbSig,
      input  errSig, errValid, upSig, dnSig, slipSig
   );

   modport slave (
      input  enable, refSig, fbSig,
      output errSig, errValid, upSig, dnSig, slipSig
   );

endinterface

// File: rtl/edge_sync.sv
// Brings an asynchronous input into the clk domain and flags its rising edges.
// SYNC_STAGES must be at least 2.
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rstN,
   input  logic asyncSig_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], asyncSig_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/counting_phase_detector.sv
// Counting phase-frequency detector: measures the signed distance between
// reference and feedback rising edges in clk cycles, with slip detection.
module counting_phase_detector
   import dpll_pkg::*;
#(
   parameter int ERR_WIDTH   = DEFAULT_ERR_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input logic                     clk,
   input logic                     rstN,
   counting_phase_detector_if.slave pd
);

   localparam int CNT_WIDTH = ERR_WIDTH - 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic signed [ERR_WIDTH-1:0] ERR_POS_MAX = $signed({1'b0, CNT_MAX});
   localparam logic signed [ERR_WIDTH-1:0] ERR_NEG_MAX = -ERR_POS_MAX;

   logic                        refRise;
   logic                        fbRise;
   pd_state_t                   state_q;
   logic [CNT_WIDTH-1:0]        cnt_q;
   logic [CNT_WIDTH-1:0]        cntInc;
   logic signed [ERR_WIDTH-1:0] err_q;
   logic signed [ERR_WIDTH-1:0] cntErrPos;
   logic signed [ERR_WIDTH-1:0] cntErrNeg;
   logic                        errValid_q;
   logic                        slip_q;
   logic                        up_q;
   logic                        dn_q;

   // Both inputs share identical synchroniser latency, so relative timing holds.
   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) uRefSync (
      .clk        (clk),
      .rstN       (rstN),
      .asyncSig_i (pd.refSig),
      .rise_o     (refRise)
   );

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) uFbSync (
      .clk        (clk),
      .rstN       (rstN),
      .asyncSig_i (pd.fbSig),
      .rise_o     (fbRise)
   );

   assign cntInc    = CNT_WIDTH'(satInc(32'(cnt_q), 32'(CNT_MAX)));
   assign cntErrPos = $signed({1'b0, cnt_q});
   assign cntErrNeg = -cntErrPos;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         err_q      <= '0;
         errValid_q <= 1'b0;
         slip_q     <= 1'b0;
         up_q       <= 1'b0;
         dn_q       <= 1'b0;
      end else begin
         errValid_q <= 1'b0;
         slip_q     <= 1'b0;
         if (!pd.enable) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (refRise && fbRise) begin
                     err_q      <= '0;
                     errValid_q <= 1'b1;
                  end else if (refRise) begin
                     state_q <= REF_LEAD;
                     cnt_q   <= CNT_ONE;
                     up_q    <= 1'b1;
                  end else if (fbRise) begin
                     state_q <= FB_LEAD;
                     cnt_q   <= CNT_ONE;
                     dn_q    <= 1'b1;
                  end
               end
               // A fresh leading edge during a measurement restarts the count.
               REF_LEAD: begin
                  if (fbRise) begin
                     err_q      <= cntErrPos;
                     errValid_q <= 1'b1;
                     if (refRise) begin
                        cnt_q <= CNT_ONE;
                     end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        up_q    <= 1'b0;
                     end
                  end else if (refRise) begin
                     err_q      <= ERR_POS_MAX;
                     errValid_q <= 1'b1;
                     slip_q     <= 1'b1;
                     cnt_q      <= CNT_ONE;
                  end else begin
                     cnt_q <= cntInc;
                  end
               end
               FB_LEAD: begin
                  if (refRise) begin
                     err_q      <= cntErrNeg;
                     errValid_q <= 1'b1;
                     if (fbRise) begin
                        cnt_q <= CNT_ONE;
                     end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        dn_q    <= 1'b0;
                     end
                  end else if (fbRise) begin
                     err_q      <= ERR_NEG_MAX;
                     errValid_q <= 1'b1;
                     slip_q     <= 1'b1;
                     cnt_q      <= CNT_ONE;
                  end else begin
                     cnt_q <= cntInc;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  up_q    <= 1'b0;
                  dn_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign pd.errSig   = err_q;
   assign pd.errValid = errValid_q;
   assign pd.slipSig  = slip_q;
   assign pd.upSig    = up_q;
   assign pd.dnSig    = dn_q;

endmodule
